// File: rtl/axi_dma_bitrate_sniffer.sv
// Passive AXI-Stream throughput tap: always-ready sink that counts accepted beats
// over fixed windows and publishes the saturated bit total at each window end.
module axi_dma_bitrate_sniffer #(
  parameter int DATA_WIDTH    = 256,
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_CYCLES = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     valid,
  output logic                     ready,
  output logic [COUNTER_WIDTH-1:0] bitrate_output
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNTER_WIDTH:0] SAT_MAX = {1'b0, {COUNTER_WIDTH{1'b1}}};
  // A bus wider than the counter range is credited as a full-scale beat.
  localparam logic [COUNTER_WIDTH:0] BEAT_BITS =
    ($clog2(DATA_WIDTH + 1) > COUNTER_WIDTH) ? SAT_MAX : (COUNTER_WIDTH + 1)'(DATA_WIDTH);

  function automatic logic [COUNTER_WIDTH-1:0] sat_add(
    input logic [COUNTER_WIDTH-1:0] a,
    input logic [COUNTER_WIDTH:0]   b
  );
    logic [COUNTER_WIDTH+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s > {1'b0, SAT_MAX}) return SAT_MAX[COUNTER_WIDTH-1:0];
    return s[COUNTER_WIDTH-1:0];
  endfunction

  logic                     r_ready;
  logic [WIN_W-1:0]         r_win_cnt;
  logic [COUNTER_WIDTH-1:0] r_acc;
  logic [COUNTER_WIDTH-1:0] r_bitrate;

  logic                     w_beat;
  logic                     w_win_last;
  logic [COUNTER_WIDTH-1:0] w_acc_next;
  logic                     w_unused_data;

  assign w_unused_data = ^data;
  assign w_beat        = valid & r_ready;
  assign w_win_last    = (r_win_cnt == WIN_LAST);
  assign w_acc_next    = sat_add(r_acc, w_beat ? BEAT_BITS : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_bitrate <= '0;
    end else begin
      r_ready <= 1'b1;
      // The closing cycle's own beat belongs to the window being published.
      if (w_win_last) begin
        r_bitrate <= w_acc_next;
        r_acc     <= '0;
        r_win_cnt <= '0;
      end else begin
        r_acc     <= w_acc_next;
        r_win_cnt <= r_win_cnt + 1'b1;
      end
    end
  end

  assign ready          = r_ready;
  assign bitrate_output = r_bitrate;

endmodule

// File: tb/tb_axi_dma_bitrate_sniffer.sv
// Scoreboard bench: a directed stimulus schedule with hand-computed window results,
// checked by an independent monitor against a default DUT and a saturating 512/16 DUT.
module tb_axi_dma_bitrate_sniffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [255:0] data_a;
  logic [511:0] data_b;
  logic         ready_a, ready_b;
  logic [31:0]  rate_a;
  logic [15:0]  rate_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  axi_dma_bitrate_sniffer dut_a (
    .clk(clk), .reset(reset), .data(data_a), .valid(valid),
    .ready(ready_a), .bitrate_output(rate_a)
  );

  axi_dma_bitrate_sniffer #(.DATA_WIDTH(512), .COUNTER_WIDTH(16), .WINDOW_CYCLES(200)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .valid(valid),
    .ready(ready_b), .bitrate_output(rate_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: sel 0 = bitrate (default), 1 = ready (default), 2 = bitrate (512/16), 3 = ready (512/16)
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        case (exp_q[i].sel)
          0:       act = rate_a;
          1:       act = {31'd0, ready_a};
          2:       act = {16'd0, rate_b};
          default: act = {31'd0, ready_b};
        endcase
        n_checks++;
        if (act !== exp_q[i].val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %0d, expected %0d",
                   exp_q[i].name, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int e;
    reset  = 1'b1;
    valid  = 1'b0;
    data_a = '0;
    data_b = '0;

    for (int k = 1; k <= 10; k++) begin
      push(k, 1, 0, "ready_in_reset");
      push(k, 0, 0, "rate_in_reset");
    end
    push(11, 1, 1, "ready_after_release");
    push(11, 3, 1, "ready_after_release_b");
    push(11, 0, 0, "rate_after_release");
    push(209, 0, 0, "rate_before_first_end");
    push(210, 0, 50944, "first_window_199_beats");
    push(210, 2, 65535, "sat_first_window");
    push(410, 0, 51200, "full_window_1");
    push(410, 2, 65535, "sat_full_window");
    push(610, 0, 51200, "full_window_2");
    push(810, 0, 51200, "full_window_3");
    push(1010, 0, 51200, "full_window_4");
    push(1011, 0, 51200, "hold_after_drop_a");
    push(1100, 0, 51200, "hold_after_drop_b");
    push(1209, 0, 51200, "hold_after_drop_c");
    push(1210, 0, 256, "single_beat_window");
    push(1210, 2, 512, "sat_single_beat");
    push(1410, 0, 25600, "toggle_window_1");
    push(1410, 2, 51200, "sat_toggle_unsaturated");
    push(1610, 0, 25600, "toggle_window_2");
    push(1810, 0, 25600, "toggle_window_3");
    push(2009, 0, 25600, "hold_before_idle_end");
    push(2010, 0, 0, "idle_window");
    push(2010, 2, 0, "sat_idle_window");
    push(2110, 0, 0, "hold_idle_mid_window");
    for (int k = 2111; k <= 2115; k++) begin
      push(k, 0, 0, "rate_mid_reset");
      push(k, 1, 0, "ready_mid_reset");
      push(k, 2, 0, "sat_rate_mid_reset");
    end
    push(2116, 1, 1, "ready_after_mid_reset");
    push(2314, 0, 0, "no_publish_before_end");
    push(2315, 0, 50944, "post_reset_first_window");
    push(2315, 2, 65535, "sat_post_reset");
    push(2515, 0, 51200, "post_reset_full_window");

    // Inputs for edge e are set just after edge e-1.
    for (int c = 0; c < 2520; c++) begin
      e = c + 1;
      reset = (e <= 10) || (e >= 2111 && e <= 2115);
      valid = (e >= 12 && e <= 1011) ||
              (e >= 1211 && e <= 1810 && ((e - 1211) % 2 == 0)) ||
              (e >= 2011);
      data_a = {8{$urandom}};
      data_b = {16{$urandom}};
      @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rate_a !== 32'd51200) begin
      n_fail++;
      $display("FAIL final_hold_rate_a: got %0d, expected 51200", rate_a);
    end
    n_checks++;
    if (rate_b !== 16'd65535) begin
      n_fail++;
      $display("FAIL final_hold_rate_b: got %0d, expected 65535", rate_b);
    end
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL final_ready_a: got %0b, expected 1", ready_a);
    end
    n_checks++;
    if (ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL final_ready_b: got %0b, expected 1", ready_b);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, expected %0d at edge %0d",
               exp_q[i].name, exp_q[i].val, exp_q[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
